// File: rtl/pwm_motor_ctrl.sv
// N-channel motor PWM generator with per-period duty ramping, boundary-synchronous
// duty updates and a decelerate/swap/re-accelerate direction reversal sequence.
module pwm_motor_ctrl #(
  parameter int CH        = 2,
  parameter int DW        = 8,
  parameter int PERIOD    = 100,
  parameter int PRESC     = 1,
  parameter int RAMP_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CH*DW-1:0] duty_tgt,
  input  logic [CH-1:0]    dir_in,
  output logic [CH-1:0]    pwm_out,
  output logic [CH-1:0]    dir_out,
  output logic [CH*DW-1:0] duty_cur,
  output logic [CH-1:0]    busy,
  output logic             period_stb
);

  localparam int PCW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PCW-1:0] PC_LAST  = PCW'(PRESC - 1);
  localparam logic [DW-1:0]  CNT_LAST = DW'(PERIOD - 1);
  localparam logic [DW:0]    PER_X    = (DW+1)'(PERIOD);
  localparam logic [DW:0]    STEP_X   = (DW+1)'(RAMP_STEP);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DECEL = 2'd1,
    SWAP  = 2'd2
  } state_t;

  logic [PCW-1:0] pc;
  logic [DW-1:0]  cnt;
  logic           tick;
  logic           bnd;

  // Targets above the period would otherwise wrap the compare; clip in DW+1 bits.
  function automatic logic [DW:0] clamp_tgt(input logic [DW-1:0] t);
    logic [DW:0] tx;
    tx = {1'b0, t};
    return (tx > PER_X) ? PER_X : tx;
  endfunction

  function automatic logic [DW:0] ramp(input logic [DW:0] cur, input logic [DW:0] goal);
    if (RAMP_STEP == 0) return goal;
    if (goal >= cur) begin
      if ((goal - cur) <= STEP_X) return goal;
      return cur + STEP_X;
    end
    if ((cur - goal) <= STEP_X) return goal;
    return cur - STEP_X;
  endfunction

  assign tick = (pc == PC_LAST);
  assign bnd  = tick && (cnt == CNT_LAST);

  // Shared timebase: prescaler, period counter and boundary strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= '0;
      cnt        <= '0;
      period_stb <= 1'b0;
    end else begin
      pc         <= tick ? '0 : pc + 1'b1;
      if (tick) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      period_stb <= bnd;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] cur;
    logic [DW-1:0] cur_nxt;
    logic          dir_q;
    logic          dir_nxt;
    logic          busy_q;
    logic          pwm_q;
    logic [DW:0]   eff;
    logic [DW:0]   to_eff;
    logic [DW:0]   to_zero;

    assign eff     = clamp_tgt(duty_tgt[i*DW +: DW]);
    assign to_eff  = ramp({1'b0, cur}, eff);
    assign to_zero = ramp({1'b0, cur}, '0);

    always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      dir_nxt   = dir_q;
      if (!en) begin
        // Disabled: drop drive at once; an interrupted reversal resumes through SWAP.
        cur_nxt = '0;
        if (state != RUN) state_nxt = SWAP;
        if (bnd) dir_nxt = dir_in[i];
      end else if (bnd) begin
        unique case (state)
          RUN: begin
            if (dir_in[i] != dir_q) begin
              if (cur == '0) begin
                dir_nxt = dir_in[i];
              end else begin
                state_nxt = DECEL;
                cur_nxt   = DW'(to_zero);
              end
            end else begin
              cur_nxt = DW'(to_eff);
            end
          end
          DECEL: begin
            if (dir_in[i] == dir_q) begin
              state_nxt = RUN;
              cur_nxt   = DW'(to_eff);
            end else begin
              cur_nxt = DW'(to_zero);
              if (to_zero == '0) state_nxt = SWAP;
            end
          end
          SWAP: begin
            cur_nxt   = '0;
            dir_nxt   = dir_in[i];
            state_nxt = RUN;
          end
          default: state_nxt = RUN;
        endcase
      end
    end

    // Channel state and registered outputs; pwm lags cnt by one clock.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state  <= RUN;
        cur    <= '0;
        dir_q  <= 1'b0;
        busy_q <= 1'b0;
        pwm_q  <= 1'b0;
      end else begin
        state  <= state_nxt;
        cur    <= cur_nxt;
        dir_q  <= dir_nxt;
        busy_q <= (state_nxt != RUN);
        pwm_q  <= en && (cnt < cur);
      end
    end

    assign pwm_out[i]            = pwm_q;
    assign dir_out[i]            = dir_q;
    assign busy[i]               = busy_q;
    assign duty_cur[i*DW +: DW]  = cur;
  end

endmodule
